// File: rtl/debug_display_pkg.sv
// Shared encodings, default display words and the channel-search helper
// for the debug display sequencer.
package debug_display_pkg;

  // Raw encoding of the mode switches
  typedef enum logic [1:0] {
    MODE_BLANK  = 2'd0,
    MODE_MANUAL = 2'd1,
    MODE_SCAN   = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  // Internal display state; the reserved mode collapses onto BLANK
  typedef enum logic [1:0] {
    ST_BLANK,
    ST_MANUAL,
    ST_SCAN
  } state_e;

  localparam int          MAX_CH          = 64;
  localparam int          CH_IW           = 6;
  localparam logic [31:0] DEF_BLANK_VALUE = 32'h0000_0FF0;
  localparam logic [31:0] DEF_ERROR_VALUE = 32'h0000_DEDE;

  // First implemented channel strictly above cur, wrapping modulo num_ch.
  // Returns cur when nothing else is implemented (including impl == 0).
  function automatic logic [CH_IW-1:0] next_impl_ch(input logic [MAX_CH-1:0] impl,
                                                    input logic [CH_IW-1:0]  cur,
                                                    input int                num_ch);
    logic [CH_IW-1:0] r;
    logic             found;
    int               idx;
    r     = cur;
    found = 1'b0;
    for (int d = 1; d <= MAX_CH; d++) begin
      if (!found && d <= num_ch) begin
        idx = (int'(cur) + d) % num_ch;
        if (impl[idx]) begin
          r     = CH_IW'(idx);
          found = 1'b1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/debug_display_sequencer_button.sv
// Pushbutton conditioner: 2-flop synchroniser followed by a falling-edge
// detector. Flops reset to the released level so reset never fires a pulse.
module button_edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_ni,
  output logic pulse_o
);

  logic s1_q, s2_q, s3_q;

  // Synchronise the raw pin and keep one extra stage for edge detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= btn_ni;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // One-cycle pulse on the press (high-to-low) transition
  assign pulse_o = s3_q & ~s2_q;

endmodule

// File: rtl/debug_display_sequencer.sv
// Debug display sequencer: chooses one debug channel (manual, timed scan or
// blank) for the hex display, with a pushbutton freeze and scan step.
module debug_display_sequencer
  import debug_display_pkg::*;
#(
  parameter int                NUM_CH       = 32,
  parameter int                DATA_W       = 32,
  parameter int                SEL_W        = 6,
  parameter int                DWELL_CYCLES = 50000000,
  parameter logic [DATA_W-1:0] BLANK_VALUE  = DATA_W'(DEF_BLANK_VALUE),
  parameter logic [DATA_W-1:0] ERROR_VALUE  = DATA_W'(DEF_ERROR_VALUE)
) (
  input  logic                     Clock_i,
  input  logic                     Resetn_i,
  input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
  input  logic [NUM_CH-1:0]        ch_impl_i,
  input  logic [1:0]               mode_i,
  input  logic [SEL_W-1:0]         sel_i,
  input  logic                     step_n_i,
  input  logic                     freeze_n_i,
  output logic [DATA_W-1:0]        display_data_o,
  output logic [SEL_W-1:0]         display_ch_o,
  output logic                     display_err_o,
  output logic                     frozen_o
);

  localparam int               CNT_W      = $clog2(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

  state_e             state_q, state_d;
  logic               frozen_q, frozen_d;
  logic [CH_IW-1:0]   scan_ch_q, scan_ch_d;
  logic [CNT_W-1:0]   dwell_q, dwell_d;
  logic [DATA_W-1:0]  display_data_q, display_data_d;
  logic [SEL_W-1:0]   display_ch_q, display_ch_d;
  logic               display_err_q, display_err_d;

  logic               step_p, freeze_p, mode_chg, sel_ok;
  logic [MAX_CH-1:0]  impl_ext;
  int                 sel_idx;

  button_edge_sync u_step (
    .clk_i  (Clock_i),
    .rst_ni (Resetn_i),
    .btn_ni (step_n_i),
    .pulse_o(step_p)
  );

  button_edge_sync u_freeze (
    .clk_i  (Clock_i),
    .rst_ni (Resetn_i),
    .btn_ni (freeze_n_i),
    .pulse_o(freeze_p)
  );

  assign impl_ext = MAX_CH'(ch_impl_i);
  assign mode_chg = (state_d != state_q);
  assign sel_ok   = (int'(sel_i) < NUM_CH) && impl_ext[CH_IW'(sel_i)];
  assign sel_idx  = sel_ok ? int'(sel_i) : 0;

  // Mode decode: state follows the switches every cycle
  always_comb begin
    state_d = ST_BLANK;
    case (mode_e'(mode_i))
      MODE_MANUAL: state_d = ST_MANUAL;
      MODE_SCAN:   state_d = ST_SCAN;
      default:     state_d = ST_BLANK;
    endcase
  end

  // Freeze toggle, scan advance and next display word; all held while frozen
  always_comb begin
    frozen_d       = frozen_q;
    scan_ch_d      = scan_ch_q;
    dwell_d        = dwell_q;
    display_data_d = display_data_q;
    display_ch_d   = display_ch_q;
    display_err_d  = display_err_q;

    if (mode_chg)      frozen_d = 1'b0;
    else if (freeze_p) frozen_d = ~frozen_q;

    if (!frozen_d) begin
      // Counter only runs while staying in scan; entering scan restarts it
      dwell_d = '0;
      if (state_d == ST_SCAN && state_q == ST_SCAN) begin
        if (step_p || dwell_q == DWELL_LAST)
          scan_ch_d = next_impl_ch(impl_ext, scan_ch_q, NUM_CH);
        else
          dwell_d = dwell_q + 1'b1;
      end

      display_data_d = ERROR_VALUE;
      display_ch_d   = '0;
      display_err_d  = 1'b1;
      case (state_d)
        ST_MANUAL: if (sel_ok) begin
          display_data_d = ch_data_i[sel_idx*DATA_W +: DATA_W];
          display_ch_d   = sel_i;
          display_err_d  = 1'b0;
        end
        ST_SCAN: if (impl_ext[scan_ch_d]) begin
          display_data_d = ch_data_i[int'(scan_ch_d)*DATA_W +: DATA_W];
          display_ch_d   = SEL_W'(scan_ch_d);
          display_err_d  = 1'b0;
        end
        default: begin
          display_data_d = BLANK_VALUE;
          display_err_d  = 1'b0;
        end
      endcase
    end
  end

  // State and display registers
  always_ff @(posedge Clock_i or negedge Resetn_i) begin
    if (!Resetn_i) begin
      state_q        <= ST_BLANK;
      frozen_q       <= 1'b0;
      scan_ch_q      <= '0;
      dwell_q        <= '0;
      display_data_q <= BLANK_VALUE;
      display_ch_q   <= '0;
      display_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      frozen_q       <= frozen_d;
      scan_ch_q      <= scan_ch_d;
      dwell_q        <= dwell_d;
      display_data_q <= display_data_d;
      display_ch_q   <= display_ch_d;
      display_err_q  <= display_err_d;
    end
  end

  assign display_data_o = display_data_q;
  assign display_ch_o   = display_ch_q;
  assign display_err_o  = display_err_q;
  assign frozen_o       = frozen_q;

endmodule
